// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One spare bit so DWELL-1 always fits, including DWELL=1.
  function automatic int dwell_width(input int dwell);
    return $clog2(dwell) + 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response and status bundle between the sweeper and its lab bench.
interface truth_table_sweeper_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic              start;
  logic              gray;
  logic [N_IN-1:0]   dut_in;
  logic [N_OUT-1:0]  dut_out;
  logic [N_OUT-1:0]  exp_out;
  logic              busy;
  logic              done;
  logic [N_IN:0]     err_count;
  logic              first_err_valid;
  logic [N_IN-1:0]   first_err_vec;

  modport master (
    output start, gray, dut_out, exp_out,
    input  dut_in, busy, done, err_count, first_err_valid, first_err_vec
  );

  modport slave (
    input  start, gray, dut_out, exp_out,
    output dut_in, busy, done, err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/truth_table_sweeper_bin2gray.sv
// Combinational binary-to-Gray converter.
module bin2gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] b,
  output logic [W-1:0] g
);
  assign g = b ^ (b >> 1);
endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: sweeps all 2^N_IN vectors, dwells, compares, logs errors.
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RUN     | driving vectors, comparing at the end of each dwell
//   DONE    | sweep complete, results held until next start
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int DWELL = 20
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int DW = dwell_width(DWELL);
  localparam int IW = N_IN + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'((1 << N_IN) - 1);

  state_t          state;
  logic [DW-1:0]   dwell_cnt;
  logic [IW-1:0]   idx;
  logic            gray_q;
  logic [IW-1:0]   idx_nxt;
  logic [N_IN-1:0] gray_nxt;
  logic [N_IN-1:0] vec_nxt;
  logic            mismatch;

  assign idx_nxt = idx + 1'b1;

  bin2gray #(.W(N_IN)) u_bin2gray (
    .b (idx_nxt[N_IN-1:0]),
    .g (gray_nxt)
  );

  assign vec_nxt  = gray_q ? gray_nxt : idx_nxt[N_IN-1:0];
  // Case inequality so X/Z on either side flags a mismatch in simulation.
  assign mismatch = (bus.dut_out !== bus.exp_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      dwell_cnt           <= '0;
      idx                 <= '0;
      gray_q              <= 1'b0;
      bus.dut_in          <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.err_count       <= '0;
      bus.first_err_valid <= 1'b0;
      bus.first_err_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state               <= ST_RUN;
            dwell_cnt           <= '0;
            idx                 <= '0;
            gray_q              <= bus.gray;
            bus.dut_in          <= '0;
            bus.busy            <= 1'b1;
            bus.done            <= 1'b0;
            bus.err_count       <= '0;
            bus.first_err_valid <= 1'b0;
            bus.first_err_vec   <= '0;
          end
        end
        ST_RUN: begin
          if (dwell_cnt == DWELL_LAST) begin
            if (mismatch) begin
              bus.err_count <= bus.err_count + 1'b1;
              if (!bus.first_err_valid) begin
                bus.first_err_valid <= 1'b1;
                bus.first_err_vec   <= bus.dut_in;
              end
            end
            if (idx == IDX_LAST) begin
              state    <= ST_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              idx        <= idx_nxt;
              dwell_cnt  <= '0;
              bus.dut_in <= vec_nxt;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus queues expected vectors/results, monitors pop and compare.
module tb_truth_table_sweeper;
  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int DWELL = 20;
  localparam int NV    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();
  truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .DWELL(DWELL)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );

  truth_table_sweeper_if #(.N_IN(3), .N_OUT(2)) bus1 ();
  truth_table_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
  );

  logic [2:0] lut [16];
  logic [2:0] flt [16];

  assign bus.exp_out  = lut[bus.dut_in];
  assign bus.dut_out  = lut[bus.dut_in] ^ flt[bus.dut_in];
  assign bus1.exp_out = {^bus1.dut_in, bus1.dut_in[0]};
  assign bus1.dut_out = {^bus1.dut_in, bus1.dut_in[0]};

  typedef struct { int errs; int fvalid; int fvec; } res_t;
  int   vec_q [$];
  int   vec1_q [$];
  res_t res_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: enumerate the sweep order and count faulty vectors.
  task automatic queue_sweep(input bit g);
    int errs = 0, fv = 0, fvec = 0;
    for (int k = 0; k < NV; k++) begin
      int v;
      v = g ? (k ^ (k >> 1)) : k;
      vec_q.push_back(v);
      if (flt[4'(v)] != 3'd0) begin
        errs++;
        if (fv == 0) begin fv = 1; fvec = v; end
      end
    end
    res_q.push_back('{errs, fv, fvec});
  endtask

  task automatic pulse_start(input bit g);
    @(negedge clk);
    bus.gray  = g;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 1000) begin @(negedge clk); n++; end
    if (!bus.done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: done never rose, got 0, expected 1", name);
    end
    @(negedge clk);
  endtask

  task automatic fill_tables(input bit faults);
    for (int v = 0; v < NV; v++) begin
      lut[4'(v)] = 3'($urandom_range(0, 7));
      flt[4'(v)] = (faults && $urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    end
  endtask

  // Main monitor: per-vector order and dwell, per-sweep length and results.
  always @(negedge clk) begin : mon
    static bit busy_p = 1'b0, done_p = 1'b0;
    static int prev_vec = 0, hold = 0, scyc = 0;
    if (!rst_n) begin
      busy_p = 1'b0; done_p = 1'b0;
    end else begin
      if (bus.busy && !busy_p) begin
        check("start_done_clr", int'(bus.done), 0);
        check("start_err_clr", int'(bus.err_count), 0);
        check("start_fvalid_clr", int'(bus.first_err_valid), 0);
        check("start_fvec_clr", int'(bus.first_err_vec), 0);
        if (vec_q.size() == 0) check("vec_q_empty", 1, 0);
        else check("vector", int'(bus.dut_in), vec_q.pop_front());
        hold = 1; scyc = 1;
      end else if (bus.busy) begin
        scyc++;
        if (int'(bus.dut_in) != prev_vec) begin
          check("dwell", hold, DWELL);
          if (vec_q.size() == 0) check("vec_q_empty", 1, 0);
          else check("vector", int'(bus.dut_in), vec_q.pop_front());
          hold = 1;
        end else hold++;
      end
      if (bus.done && !done_p) begin
        res_t r;
        check("last_dwell", hold, DWELL);
        check("sweep_len", scyc, NV * DWELL);
        check("leftover_vecs", vec_q.size(), 0);
        if (res_q.size() == 0) check("res_q_empty", 1, 0);
        else begin
          r = res_q.pop_front();
          check("err_count", int'(bus.err_count), r.errs);
          check("first_err_valid", int'(bus.first_err_valid), r.fvalid);
          check("first_err_vec", int'(bus.first_err_vec), r.fvec);
        end
      end
      busy_p = bus.busy; done_p = bus.done; prev_vec = int'(bus.dut_in);
    end
  end

  // DWELL=1 monitor: one new vector every busy cycle.
  always @(negedge clk) begin : mon1
    static bit done_p1 = 1'b0;
    static int cnt = 0;
    if (!rst_n) begin
      done_p1 = 1'b0; cnt = 0;
    end else begin
      if (bus1.busy) begin
        if (vec1_q.size() == 0) check("vec1_q_empty", 1, 0);
        else check("vector1", int'(bus1.dut_in), vec1_q.pop_front());
        cnt++;
      end
      if (bus1.done && !done_p1) begin
        check("sweep_len1", cnt, 8);
        check("err_count1", int'(bus1.err_count), 0);
        cnt = 0;
      end
      done_p1 = bus1.done;
    end
  end

  initial begin
    bus.start = 1'b0; bus.gray = 1'b0;
    bus1.start = 1'b0; bus1.gray = 1'b0;
    fill_tables(1'b0);
    repeat (3) @(negedge clk);
    check("rst_dut_in", int'(bus.dut_in), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err_count", int'(bus.err_count), 0);
    check("rst_fvalid", int'(bus.first_err_valid), 0);
    check("rst_fvec", int'(bus.first_err_vec), 0);
    rst_n = 1'b1;

    // Clean binary sweep.
    queue_sweep(1'b0); pulse_start(1'b0); wait_done("binary_clean");

    // Bit 2 stuck-at-0 where golden bit 2 is high only at 5 and C.
    for (int v = 0; v < NV; v++) begin
      lut[4'(v)] = {(v == 5 || v == 12), 2'($urandom_range(0, 3))};
      flt[4'(v)] = {lut[4'(v)][2], 2'b00};
    end
    queue_sweep(1'b0); pulse_start(1'b0); wait_done("stuck_at");
    check("stuck_err_count", int'(bus.err_count), 2);
    check("stuck_first_vec", int'(bus.first_err_vec), 5);

    // Clean Gray sweep started from DONE, with a stray start mid-run.
    fill_tables(1'b0);
    queue_sweep(1'b1); pulse_start(1'b1);
    repeat (57) @(negedge clk);
    pulse_start(1'b0);
    wait_done("gray_clean");

    // Randomized faults and order.
    for (int s = 0; s < 4; s++) begin
      bit g;
      g = 1'($urandom_range(0, 1));
      fill_tables(1'b1);
      queue_sweep(g); pulse_start(g); wait_done("random");
    end

    // Reset mid-sweep at vector 7 with errors already logged.
    fill_tables(1'b0);
    flt[4'd2] = 3'b001;
    queue_sweep(1'b0); pulse_start(1'b0);
    begin
      int n = 0;
      while (bus.dut_in != 4'd7 && n < 500) begin @(negedge clk); n++; end
      if (bus.dut_in != 4'd7) check("reach_vec7", int'(bus.dut_in), 7);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dut_in", int'(bus.dut_in), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_err_count", int'(bus.err_count), 0);
    check("mid_rst_fvalid", int'(bus.first_err_valid), 0);
    check("mid_rst_fvec", int'(bus.first_err_vec), 0);
    vec_q.delete(); res_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    fill_tables(1'b1);
    queue_sweep(1'b0); pulse_start(1'b0); wait_done("after_reset");

    // DWELL=1, N_IN=3 instance.
    begin
      bit g;
      int n = 0;
      g = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) vec1_q.push_back(g ? (k ^ (k >> 1)) : k);
      @(negedge clk); bus1.gray = g; bus1.start = 1'b1;
      @(negedge clk); bus1.start = 1'b0;
      while (!bus1.done && n < 100) begin @(negedge clk); n++; end
      if (!bus1.done) check("dwell1_done", 0, 1);
      @(negedge clk);
      check("leftover_vecs1", vec1_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
